// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if : command, ALU-operand and response signals of alu_issue_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_issue_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_funct3;
   logic        cmd_funct7b5;
   logic        cmd_is_imm;
   logic        cmd_fwd;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_err;
   logic        busy;

   modport master (
      output cmd_valid, cmd_funct3, cmd_funct7b5, cmd_is_imm, cmd_fwd, cmd_a, cmd_b,
      input  cmd_ready,
      input  alu_op1, alu_op2, alu_op,
      output alu_result, alu_zero,
      input  rsp_valid, rsp_result, rsp_zero, rsp_err, busy,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid, cmd_funct3, cmd_funct7b5, cmd_is_imm, cmd_fwd, cmd_a, cmd_b,
      output cmd_ready,
      output alu_op1, alu_op2, alu_op,
      input  alu_result, alu_zero,
      output rsp_valid, rsp_result, rsp_zero, rsp_err, busy,
      input  rsp_ready
   );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl : decodes RISC-V ALU commands, drives an external ALU, returns result
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_issue_ctrl (
   input  wire logic  clk,
   input  wire logic  rst_n,
   alu_issue_if.slave bus
);

   localparam logic [3:0] c_ALUOP_AND  = 4'b0000;
   localparam logic [3:0] c_ALUOP_OR   = 4'b0001;
   localparam logic [3:0] c_ALUOP_ADD  = 4'b0010;
   localparam logic [3:0] c_ALUOP_SUB  = 4'b0110;
   localparam logic [3:0] c_ALUOP_LESS = 4'b0111;
   localparam logic [3:0] c_ALUOP_SRL  = 4'b1000;
   localparam logic [3:0] c_ALUOP_SLL  = 4'b1001;
   localparam logic [3:0] c_ALUOP_SRA  = 4'b1010;
   localparam logic [3:0] c_ALUOP_XOR  = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_last_result;
   logic [31:0] r_alu_op1;
   logic [31:0] r_alu_op2;
   logic [3:0]  r_alu_op;
   logic        r_cmd_ready;
   logic        r_busy;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_result;
   logic        r_rsp_zero;
   logic        r_rsp_err;

   logic [3:0]  w_dec_op;
   logic        w_dec_illegal;

   always_comb begin
      w_dec_op      = c_ALUOP_AND;
      w_dec_illegal = 1'b0;
      case (bus.cmd_funct3)
         3'b000:  w_dec_op = (bus.cmd_funct7b5 && !bus.cmd_is_imm) ? c_ALUOP_SUB : c_ALUOP_ADD;
         3'b001:  w_dec_op = c_ALUOP_SLL;
         3'b010:  w_dec_op = c_ALUOP_LESS;
         3'b011:  w_dec_illegal = 1'b1;
         3'b100:  w_dec_op = c_ALUOP_XOR;
         3'b101:  w_dec_op = bus.cmd_funct7b5 ? c_ALUOP_SRA : c_ALUOP_SRL;
         3'b110:  w_dec_op = c_ALUOP_OR;
         default: w_dec_op = c_ALUOP_AND;
      endcase
   end

   // ALU operand registers double as the outputs; they are zero except in EXEC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_last_result <= 32'd0;
         r_alu_op1     <= 32'd0;
         r_alu_op2     <= 32'd0;
         r_alu_op      <= 4'd0;
         r_cmd_ready   <= 1'b1;
         r_busy        <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_result  <= 32'd0;
         r_rsp_zero    <= 1'b0;
         r_rsp_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (w_dec_illegal) begin
                     r_state      <= S_RESP;
                     r_rsp_valid  <= 1'b1;
                     r_rsp_result <= 32'd0;
                     r_rsp_zero   <= 1'b0;
                     r_rsp_err    <= 1'b1;
                  end else begin
                     r_state   <= S_EXEC;
                     r_alu_op1 <= bus.cmd_fwd ? r_last_result : bus.cmd_a;
                     r_alu_op2 <= bus.cmd_b;
                     r_alu_op  <= w_dec_op;
                  end
               end
            end
            S_EXEC: begin
               r_state       <= S_RESP;
               r_rsp_valid   <= 1'b1;
               r_rsp_result  <= bus.alu_result;
               r_rsp_zero    <= bus.alu_zero;
               r_rsp_err     <= 1'b0;
               r_last_result <= bus.alu_result;
               r_alu_op1     <= 32'd0;
               r_alu_op2     <= 32'd0;
               r_alu_op      <= 4'd0;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_alu_op1   <= 32'd0;
               r_alu_op2   <= 32'd0;
               r_alu_op    <= 4'd0;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.alu_op1    = r_alu_op1;
   assign bus.alu_op2    = r_alu_op2;
   assign bus.alu_op     = r_alu_op;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_zero   = r_rsp_zero;
   assign bus.rsp_err    = r_rsp_err;
   assign bus.busy       = r_busy;

endmodule

`default_nettype wire
